// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - write-only character LCD bus sequencer with setup/pulse/hold/exec timing
module lcd_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        ack_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    // Reload values: each timed state lasts exactly its parameter, counting down to zero.
    localparam logic [15:0] C_SETUP = 16'(T_SETUP - 1);
    localparam logic [15:0] C_PULSE = 16'(T_PULSE - 1);
    localparam logic [15:0] C_HOLD  = 16'(T_HOLD - 1);
    localparam logic [15:0] C_EXEC  = 16'(T_EXEC - 1);

    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic        r_on;
    logic        r_rs, w_rs_n;
    logic [7:0]  r_data, w_data_n;
    logic        r_en, w_en_n;
    logic        r_req, w_req_n;
    logic        r_ack, w_ack_n;

    logic        w_on;
    logic        w_req;
    logic        w_pending;
    logic        w_cnt_zero;
    logic [15:0] w_cnt_dec;
    logic        w_unused;

    assign w_on       = lcd_word_i[31];
    assign w_req      = lcd_word_i[30];
    assign w_pending  = (w_req != r_ack);
    assign w_cnt_zero = (r_cnt == 16'd0);
    assign w_cnt_dec  = r_cnt - 16'd1;
    assign w_unused   = ^{lcd_word_i[29:10], lcd_word_i[8]};

    // State and output registers; reset drops the strobe and every output at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_on    <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_en    <= 1'b0;
            r_req   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_on    <= w_on;
            r_rs    <= w_rs_n;
            r_data  <= w_data_n;
            r_en    <= w_en_n;
            r_req   <= w_req_n;
            r_ack   <= w_ack_n;
        end
    end

    // Next-state and next-output logic; the bus word is only sampled on the accept edge.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_rs_n    = r_rs;
        w_data_n  = r_data;
        w_req_n   = r_req;
        w_ack_n   = r_ack;
        case (r_state)
            S_IDLE: begin
                if (w_pending && w_on) begin
                    w_state_n = S_SETUP;
                    w_cnt_n   = C_SETUP;
                    w_rs_n    = lcd_word_i[9];
                    w_data_n  = lcd_word_i[7:0];
                    w_req_n   = w_req;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_n = S_PULSE;
                    w_cnt_n   = C_PULSE;
                end else begin
                    w_cnt_n   = w_cnt_dec;
                end
            end
            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_n = S_HOLD;
                    w_cnt_n   = C_HOLD;
                end else begin
                    w_cnt_n   = w_cnt_dec;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_n = S_EXEC;
                    w_cnt_n   = C_EXEC;
                end else begin
                    w_cnt_n   = w_cnt_dec;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = 16'd0;
                    w_ack_n   = r_req;
                end else begin
                    w_cnt_n   = w_cnt_dec;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 16'd0;
            end
        endcase
        // Registered strobe: high for exactly the cycles spent in PULSE.
        w_en_n = (w_state_n == S_PULSE);
    end

    assign lcd_on_o   = r_on;
    assign lcd_rs_o   = r_rs;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = r_en;
    assign lcd_data_o = r_data;
    assign busy_o     = (r_state != S_IDLE);
    assign ack_o      = r_ack;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl with a transaction-level timing model
module tb_lcd_ctrl;

    localparam int TS  = 2;
    localparam int TP  = 3;
    localparam int TH  = 2;
    localparam int TE  = 4;
    localparam int TOT = TS + TP + TH + TE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word;
    logic        lcd_on, lcd_rs, lcd_rw, lcd_en, busy, ack;
    logic [7:0]  lcd_data;

    lcd_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .lcd_word_i (word),
        .lcd_on_o   (lcd_on),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_en_o   (lcd_en),
        .lcd_data_o (lcd_data),
        .busy_o     (busy),
        .ack_o      (ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        bit       rs;
        bit [7:0] data;
        bit       ack;
        int       a;
        int       done;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what software has written and when the panel will next be free.
    bit       m_on = 1'b0;
    bit       m_req = 1'b0;
    bit       m_rs = 1'b0;
    bit [7:0] m_data = 8'h00;
    int       m_done = 0;
    int       m_last_a = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic drive();
        word = {m_on, m_req, 20'($urandom), m_rs, 1'($urandom), m_data};
    endtask

    // Request becomes visible on the next edge; accepted then, or the cycle after the previous completes.
    task automatic push();
        int e, a;
        e = cyc + 1;
        a = (e > m_done + 1) ? e : m_done + 1;
        sb.push_back('{rs: m_rs, data: m_data, ack: m_req, a: a, done: a + TOT});
        m_last_a = a;
        m_done   = a + TOT;
    endtask

    task automatic issue(input bit rs, input bit [7:0] data);
        m_rs   = rs;
        m_data = data;
        m_req  = ~m_req;
        drive();
        push();
    endtask

    // Monitor: times EN and BUSY, and scores a transaction whenever ACK toggles.
    bit       p_ack, p_en, p_busy;
    int       en_start, en_len, busy_start;
    bit       en_rs;
    bit [7:0] en_data;
    exp_t     me;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_ack  = 1'b0;
            p_en   = 1'b0;
            p_busy = 1'b0;
        end else begin
            if (lcd_en && !p_en) begin
                en_start = cyc;
                en_rs    = lcd_rs;
                en_data  = lcd_data;
                chk("en_rise_expected", int'(sb.size() > 0), 1);
            end
            if (!lcd_en && p_en) en_len = cyc - en_start;
            if (busy && !p_busy) busy_start = cyc;
            if (ack != p_ack) begin
                chk("ack_toggle_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    me = sb.pop_front();
                    chk("ack_value", ack, me.ack);
                    chk("ack_cycle", cyc, me.done);
                    chk("busy_start", busy_start, me.a);
                    chk("busy_at_ack", busy, 0);
                    chk("en_start", en_start, me.a + TS);
                    chk("en_len", en_len, TP);
                    chk("rs_at_pulse", en_rs, me.rs);
                    chk("data_at_pulse", en_data, me.data);
                    chk("data_at_ack", lcd_data, me.data);
                    chk("rs_at_ack", lcd_rs, me.rs);
                    chk("rw", lcd_rw, 0);
                end
            end
            p_ack  = ack;
            p_en   = lcd_en;
            p_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        word  = 32'h0;
        #1 rst_n = 1'b0;
        m_on = 1'b1; m_req = 1'b1; m_rs = 1'b1; m_data = 8'h41;
        word = 32'hC000_0241;
        repeat (3) tick();
        chk("rst_on", lcd_on, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);

        // Pending request present at reset release starts right away; bus change in PULSE ignored.
        rst_n = 1'b1;
        push();
        wait_until(m_last_a + TS + 1);
        word[7:0] = 8'hFF;
        wait_until(m_done + 1);

        // Toggle while the panel is off: nothing moves until ON returns.
        m_on = 1'b0; m_req = ~m_req; m_rs = 1'b0; m_data = 8'h38;
        drive();
        repeat (6) tick();
        chk("off_busy", busy, 0);
        chk("off_en", lcd_en, 0);
        chk("off_on", lcd_on, 0);
        m_on = 1'b1;
        drive();
        push();
        tick();
        chk("on_follows", lcd_on, 1);
        chk("on_accept_busy", busy, 1);

        // Single toggle during EXEC queues a second transfer on the first IDLE cycle.
        wait_until(m_done - 1);
        issue(1'b1, 8'h55);
        // Double toggle during EXEC of that transfer leaves nothing pending.
        wait_until(m_done - 2);
        m_req = ~m_req; drive();
        tick();
        m_req = ~m_req; drive();
        wait_until(m_done + 6);
        chk("double_toggle_busy", busy, 0);

        // ON dropped during HOLD: lcd_on follows, transfer still completes on time.
        issue(1'b0, 8'hA5);
        wait_until(m_last_a + TS + TP);
        m_on = 1'b0; drive();
        tick();
        chk("on_drop_hold", lcd_on, 0);
        wait_until(m_done + 2);
        m_on = 1'b1; drive();
        tick();

        // Randomised traffic: back-to-back, queued-during-transfer, and bus noise mid-transfer.
        for (int i = 0; i < 24; i++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode == 1) begin
                wait_until($urandom_range(m_last_a, m_done));
            end else begin
                wait_until(m_done + $urandom_range(0, 3));
            end
            issue(1'($urandom), 8'($urandom));
            if (mode == 2) begin
                wait_until(m_last_a);
                word[9:0] = 10'($urandom);
            end
        end
        wait_until(m_done + 2);

        // Asynchronous reset while EN is high.
        if (!m_req) begin
            issue(1'b1, 8'h3C);
            wait_until(m_done + 1);
        end
        issue(1'b1, 8'h7E);
        wait_until(m_last_a + TS + 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_en", lcd_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ack", ack, 0);
        chk("async_rst_data", lcd_data, 0);
        sb.delete();
        m_req = 1'b0; m_on = 1'b1; m_done = 0;
        drive();
        repeat (2) tick();
        rst_n = 1'b1;
        issue(1'b0, 8'h01);
        wait_until(m_done + 3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
